idex_stage: RTL and testbench
=============================

# idex_stage

ID/EX pipeline stage of the 5-stage RV32 core: registers decoded operands and control from Decode and presents the final ALU operands `srca_e`/`srcb_e` and `alucontrol_e` to the ALU in Execute. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, supports hold and flush (bubble) from the hazard unit, and flags load-use hazards back to Decode.

## Interface
- Parameters:
- `XLEN`, 32, datapath width
- `REGW`, 5, register index width
- Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `valid_d`  in  1  Decode slot holds a real instruction
- `rd1_d`, `rd2_d`  in  XLEN  register-file read data
- `immext_d`, `pc_d`, `pcplus4_d`  in  XLEN  immediate, PC, PC+4
- `rs1_d`, `rs2_d`, `rd_d`  in  REGW  register indices
- `alucontrol_d`  in  3  ALU op (000 add … 111 srl)
- `alusrc_d`  in  1  1 = B operand is the immediate
- `regwrite_d`, `memwrite_d`, `branch_d`, `jump_d`  in  1  control
- `resultsrc_d`  in  2  00 ALU, 01 load, 10 PC+4
- `hold_e`  in  1  keep current EX contents
- `flush_e`  in  1  replace EX contents with a bubble
- `rd_m`, `regwrite_m`, `aluresult_m`  in  REGW/1/XLEN  EX/MEM forwarding source
- `rd_w`, `regwrite_w`, `result_w`  in  REGW/1/XLEN  MEM/WB forwarding source
- `srca_e`, `srcb_e`  out  XLEN  ALU operands
- `writedata_e`  out  XLEN  forwarded rs2 for stores
- `alucontrol_e`  out  3  registered ALU op
- `valid_e`, `regwrite_e`, `memwrite_e`, `branch_e`, `jump_e`, `resultsrc_e`, `rd_e`, `immext_e`, `pc_e`, `pcplus4_e`  out  –  registered copies
- `lduse_stall`  out  1  load in EX whose `rd_e` matches `rs1_d`/`rs2_d`

## Operation
- Register update priority per edge: `flush_e` > `hold_e` > load. Flush writes a bubble; hold keeps all fields; otherwise all `_d` inputs are captured.
- Bubble: `valid_e`, `regwrite_e`, `memwrite_e`, `branch_e`, `jump_e` = 0; `alucontrol_e` = 000; `resultsrc_e` = 00; `rd_e` = 0; data fields 0.
- An invalid capture (`valid_d` = 0) also forces the control bits to bubble values.
- Forwarding, evaluated independently for rs1 and rs2 of the EX instruction:
  - EX/MEM when `regwrite_m` && `rd_m` != 0 && `rd_m` == rs_e → `aluresult_m`.
  - Else MEM/WB when `regwrite_w` && `rd_w` != 0 && `rd_w` == rs_e → `result_w`.
  - Else the registered `rd1_e`/`rd2_e`.
- `srca_e` = forwarded rs1. `srcb_e` = `alusrc_e` ? `immext_e` : forwarded rs2. `writedata_e` = forwarded rs2 always.
- `lduse_stall` = `valid_e` && `resultsrc_e` == 01 && `rd_e` != 0 && (`rd_e` == `rs1_d` || `rd_e` == `rs2_d`). It is combinational. The hazard unit turns it into a Decode stall plus `flush_e`.
- x0 is never forwarded. Widths are exact; no arithmetic in this block.

## Timing
- Latency: one cycle from `_d` inputs to registered `_e` outputs.
- Forwarding muxes and `lduse_stall` are combinational on current registered state and M/W inputs, so they resolve in the same cycle.
- Reset: asynchronous assert forces the bubble state immediately. All outputs read 0, except that forwarded `srca_e`/`srcb_e`/`writedata_e` may reflect active M/W sources. Deassert takes effect at the next rising edge.
- `hold_e` and `flush_e` asserted together: flush wins.
- A held instruction re-evaluates forwarding every cycle, so operands track newer M/W results.

## Configuration
- `IDEX_FORWARDING_EN` defined: forwarding muxes as above.
- `IDEX_FORWARDING_EN` undefined: operands come straight from registered `rd1_e`/`rd2_e`.
  - `lduse_stall` then asserts for any `valid_e` && `regwrite_e` && `rd_e` != 0 matching `rs1_d`/`rs2_d`, not only loads.
  - The M/W ports are ignored.

## Structure
- Shared package `riscv_pkg`:
  - ALU op constants `ALU_ADD`…`ALU_SRL` (3 bits).
  - `RESULTSRC_ALU/LOAD/PC4`.
  - `XLEN`, `REGW`.
  - The bubble control constant.
- Sub-module `fwd_mux`: one rs index plus M/W sources in, forwarded value out. Instantiated twice (rs1, rs2).

## Test plan
- Reset: `reset_n` = 0 mid-stream → `valid_e` = 0, `regwrite_e` = 0, `alucontrol_e` = 000 asynchronously.
- EX/MEM forward: EX rs1 = 5; `rd_m` = 5, `regwrite_m` = 1, `aluresult_m` = 0x1234; `rd_w` = 5, `result_w` = 0xBEEF → `srca_e` = 0x1234.
- x0 guard and immediate select: `rd_m` = 0, `regwrite_m` = 1, `aluresult_m` = 0xFFFF_FFFF, rs2_e = 0, `rd2_e` = 0, `alusrc_e` = 0 → `srcb_e` = 0. With `alusrc_e` = 1, `immext_e` = 0x10 → `srcb_e` = 0x10 and `writedata_e` = 0.
- Load-use: EX holds lw x7 (`resultsrc_e` = 01); Decode `rs2_d` = 7 → `lduse_stall` = 1. Next edge with `flush_e` = 1 → `valid_e` = 0.
- Hold vs flush: `hold_e` = 1 for 3 cycles → outputs unchanged. `hold_e` = `flush_e` = 1 → bubble.
- Macro off: same stimulus as the EX/MEM forward case → `srca_e` = registered `rd1_e`. An ALU-op producer in EX matching `rs1_d` → `lduse_stall` = 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath widths, ALU op encodings, result-source
// encodings and the control bundle carried through ID/EX with its bubble value.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] RESULTSRC_ALU  = 2'b00;
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
  localparam logic [1:0] RESULTSRC_PC4  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [1:0] resultsrc;
    logic [2:0] alucontrol;
    logic       alusrc;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/idex_stage_if.sv
// ID/EX bundle: Decode-side inputs, hazard controls, EX/MEM and MEM/WB
// forwarding sources, and the registered/forwarded Execute-side outputs.
// master: the pipeline around the stage; slave: idex_stage itself.
interface idex_stage_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned REGW = riscv_pkg::REGW
);
  logic            valid_d;
  logic [XLEN-1:0] rd1_d, rd2_d, immext_d, pc_d, pcplus4_d;
  logic [REGW-1:0] rs1_d, rs2_d, rd_d;
  logic [2:0]      alucontrol_d;
  logic            alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d;
  logic [1:0]      resultsrc_d;
  logic            hold_e, flush_e;
  logic [REGW-1:0] rd_m, rd_w;
  logic            regwrite_m, regwrite_w;
  logic [XLEN-1:0] aluresult_m, result_w;
  logic [XLEN-1:0] srca_e, srcb_e, writedata_e, immext_e, pc_e, pcplus4_e;
  logic [2:0]      alucontrol_e;
  logic            valid_e, regwrite_e, memwrite_e, branch_e, jump_e;
  logic [1:0]      resultsrc_e;
  logic [REGW-1:0] rd_e;
  logic            lduse_stall;

  modport master (
    output valid_d, rd1_d, rd2_d, immext_d, pc_d, pcplus4_d, rs1_d, rs2_d, rd_d,
           alucontrol_d, alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d, resultsrc_d,
           hold_e, flush_e, rd_m, regwrite_m, aluresult_m, rd_w, regwrite_w, result_w,
    input  srca_e, srcb_e, writedata_e, immext_e, pc_e, pcplus4_e, alucontrol_e, valid_e,
           regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e, rd_e, lduse_stall
  );

  modport slave (
    input  valid_d, rd1_d, rd2_d, immext_d, pc_d, pcplus4_d, rs1_d, rs2_d, rd_d,
           alucontrol_d, alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d, resultsrc_d,
           hold_e, flush_e, rd_m, regwrite_m, aluresult_m, rd_w, regwrite_w, result_w,
    output srca_e, srcb_e, writedata_e, immext_e, pc_e, pcplus4_e, alucontrol_e, valid_e,
           regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e, rd_e, lduse_stall
  );
endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one source register.
// Ports: rs (EX source index), reg_val (registered operand), rd_m/regwrite_m/
// aluresult_m (EX/MEM source), rd_w/regwrite_w/result_w (MEM/WB source),
// fwd_val (operand to use). EX/MEM beats MEM/WB; x0 is never forwarded.
module fwd_mux #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] reg_val,
  input  logic [REGW-1:0] rd_m,
  input  logic            regwrite_m,
  input  logic [XLEN-1:0] aluresult_m,
  input  logic [REGW-1:0] rd_w,
  input  logic            regwrite_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] fwd_val
);
  always_comb begin
    fwd_val = reg_val;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) begin
      fwd_val = aluresult_m;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == rs)) begin
      fwd_val = result_w;
    end
  end
endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Ports: clk, reset_n (async, active-low), bus (idex_stage_if.slave) carrying
// Decode inputs, hold/flush, M/W forwarding sources and Execute outputs.
// Macro IDEX_FORWARDING_EN: when defined, operands are forwarded from EX/MEM
// and MEM/WB and only loads raise lduse_stall; when undefined, operands come
// from the registered values and any register-writing producer in EX stalls.
module idex_stage
  import riscv_pkg::ctrl_t;
  import riscv_pkg::CTRL_BUBBLE;
  import riscv_pkg::RESULTSRC_LOAD;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned REGW = riscv_pkg::REGW
) (
  input logic         clk,
  input logic         reset_n,
  idex_stage_if.slave bus
);
  ctrl_t           e_ctrl_q, e_ctrl_d;
  logic [XLEN-1:0] e_rd1_q, e_rd1_d, e_rd2_q, e_rd2_d, e_imm_q, e_imm_d;
  logic [XLEN-1:0] e_pc_q, e_pc_d, e_pc4_q, e_pc4_d;
  logic [REGW-1:0] e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d, e_rd_q, e_rd_d;

  // Priority: flush > hold > load.
  always_comb begin
    e_ctrl_d = e_ctrl_q;
    e_rd1_d  = e_rd1_q;
    e_rd2_d  = e_rd2_q;
    e_imm_d  = e_imm_q;
    e_pc_d   = e_pc_q;
    e_pc4_d  = e_pc4_q;
    e_rs1_d  = e_rs1_q;
    e_rs2_d  = e_rs2_q;
    e_rd_d   = e_rd_q;
    if (bus.flush_e) begin
      e_ctrl_d = CTRL_BUBBLE;
      e_rd1_d  = '0;
      e_rd2_d  = '0;
      e_imm_d  = '0;
      e_pc_d   = '0;
      e_pc4_d  = '0;
      e_rs1_d  = '0;
      e_rs2_d  = '0;
      e_rd_d   = '0;
    end else if (!bus.hold_e) begin
      e_ctrl_d = '{valid:      bus.valid_d,
                   regwrite:   bus.regwrite_d,
                   memwrite:   bus.memwrite_d,
                   branch:     bus.branch_d,
                   jump:       bus.jump_d,
                   resultsrc:  bus.resultsrc_d,
                   alucontrol: bus.alucontrol_d,
                   alusrc:     bus.alusrc_d};
      e_rd1_d  = bus.rd1_d;
      e_rd2_d  = bus.rd2_d;
      e_imm_d  = bus.immext_d;
      e_pc_d   = bus.pc_d;
      e_pc4_d  = bus.pcplus4_d;
      e_rs1_d  = bus.rs1_d;
      e_rs2_d  = bus.rs2_d;
      e_rd_d   = bus.rd_d;
      // An empty Decode slot must not write, branch or look like a hazard source.
      if (!bus.valid_d) begin
        e_ctrl_d = CTRL_BUBBLE;
        e_rd_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_ctrl_q <= CTRL_BUBBLE;
      e_rd1_q  <= '0;
      e_rd2_q  <= '0;
      e_imm_q  <= '0;
      e_pc_q   <= '0;
      e_pc4_q  <= '0;
      e_rs1_q  <= '0;
      e_rs2_q  <= '0;
      e_rd_q   <= '0;
    end else begin
      e_ctrl_q <= e_ctrl_d;
      e_rd1_q  <= e_rd1_d;
      e_rd2_q  <= e_rd2_d;
      e_imm_q  <= e_imm_d;
      e_pc_q   <= e_pc_d;
      e_pc4_q  <= e_pc4_d;
      e_rs1_q  <= e_rs1_d;
      e_rs2_q  <= e_rs2_d;
      e_rd_q   <= e_rd_d;
    end
  end

  logic fwd_en;
  logic hazard_src;

`ifdef IDEX_FORWARDING_EN
  assign fwd_en     = 1'b1;
  assign hazard_src = (e_ctrl_q.resultsrc == RESULTSRC_LOAD);
`else
  // Without forwarding every pending register write is a hazard for Decode.
  assign fwd_en     = 1'b0;
  assign hazard_src = e_ctrl_q.regwrite;
`endif

  logic [XLEN-1:0] fwd_a, fwd_b;

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
    .rs          (e_rs1_q),
    .reg_val     (e_rd1_q),
    .rd_m        (bus.rd_m),
    .regwrite_m  (bus.regwrite_m & fwd_en),
    .aluresult_m (bus.aluresult_m),
    .rd_w        (bus.rd_w),
    .regwrite_w  (bus.regwrite_w & fwd_en),
    .result_w    (bus.result_w),
    .fwd_val     (fwd_a)
  );

  fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
    .rs          (e_rs2_q),
    .reg_val     (e_rd2_q),
    .rd_m        (bus.rd_m),
    .regwrite_m  (bus.regwrite_m & fwd_en),
    .aluresult_m (bus.aluresult_m),
    .rd_w        (bus.rd_w),
    .regwrite_w  (bus.regwrite_w & fwd_en),
    .result_w    (bus.result_w),
    .fwd_val     (fwd_b)
  );

  assign bus.srca_e       = fwd_a;
  assign bus.srcb_e       = e_ctrl_q.alusrc ? e_imm_q : fwd_b;
  assign bus.writedata_e  = fwd_b;
  assign bus.alucontrol_e = e_ctrl_q.alucontrol;
  assign bus.valid_e      = e_ctrl_q.valid;
  assign bus.regwrite_e   = e_ctrl_q.regwrite;
  assign bus.memwrite_e   = e_ctrl_q.memwrite;
  assign bus.branch_e     = e_ctrl_q.branch;
  assign bus.jump_e       = e_ctrl_q.jump;
  assign bus.resultsrc_e  = e_ctrl_q.resultsrc;
  assign bus.rd_e         = e_rd_q;
  assign bus.immext_e     = e_imm_q;
  assign bus.pc_e         = e_pc_q;
  assign bus.pcplus4_e    = e_pc4_q;

  assign bus.lduse_stall = e_ctrl_q.valid && hazard_src && (e_rd_q != '0) &&
                           ((e_rd_q == bus.rs1_d) || (e_rd_q == bus.rs2_d));
endmodule

// File: tb/tb_idex_stage.sv
module tb_idex_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  idex_stage_if bus ();

  idex_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

`ifdef IDEX_FORWARDING_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  alu;
    logic        alusrc;
    logic [4:0]  rdm;
    logic        wem;
    logic [31:0] resm;
    logic [4:0]  rdw;
    logic        wew;
    logic [31:0] resw;
    logic [31:0] a_fwd, b_fwd, wd_fwd, a_raw, b_raw, wd_raw;
    logic [2:0]  exp_alu;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.valid_d = 0; bus.rd1_d = 0; bus.rd2_d = 0; bus.immext_d = 0;
    bus.pc_d = 0; bus.pcplus4_d = 0; bus.rs1_d = 0; bus.rs2_d = 0; bus.rd_d = 0;
    bus.alucontrol_d = 0; bus.alusrc_d = 0; bus.regwrite_d = 0; bus.memwrite_d = 0;
    bus.branch_d = 0; bus.jump_d = 0; bus.resultsrc_d = 0;
    bus.hold_e = 0; bus.flush_e = 0;
    bus.rd_m = 0; bus.regwrite_m = 0; bus.aluresult_m = 0;
    bus.rd_w = 0; bus.regwrite_w = 0; bus.result_w = 0;
  endtask

  task automatic drive_instr(input logic [31:0] rd1, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [2:0] alu, input logic [1:0] rsrc);
    bus.valid_d = 1; bus.regwrite_d = 1; bus.rd1_d = rd1; bus.rd2_d = 32'h0;
    bus.rs1_d = rs1; bus.rs2_d = rs2; bus.rd_d = rd; bus.alucontrol_d = alu;
    bus.resultsrc_d = rsrc; bus.alusrc_d = 0;
  endtask

  function automatic vec_t mk(
      input logic v, input logic [31:0] rd1, rd2, imm, input logic [4:0] rs1, rs2, rd,
      input logic [2:0] alu, input logic alusrc,
      input logic [4:0] rdm, input logic wem, input logic [31:0] resm,
      input logic [4:0] rdw, input logic wew, input logic [31:0] resw,
      input logic [31:0] a_f, b_f, wd_f, a_r, b_r, wd_r, input logic [2:0] ealu);
    vec_t t;
    t.valid = v; t.rd1 = rd1; t.rd2 = rd2; t.imm = imm; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.alu = alu; t.alusrc = alusrc; t.rdm = rdm; t.wem = wem; t.resm = resm;
    t.rdw = rdw; t.wew = wew; t.resw = resw;
    t.a_fwd = a_f; t.b_fwd = b_f; t.wd_fwd = wd_f;
    t.a_raw = a_r; t.b_raw = b_r; t.wd_raw = wd_r; t.exp_alu = ealu;
    return t;
  endfunction

  initial begin
    clear_inputs();
    // Reset state, asserted from time zero.
    #1;
    check("reset_valid_e", {31'b0, bus.valid_e}, 32'h0);
    check("reset_regwrite_e", {31'b0, bus.regwrite_e}, 32'h0);
    check("reset_alucontrol_e", {29'b0, bus.alucontrol_e}, 32'h0);
    check("reset_lduse", {31'b0, bus.lduse_stall}, 32'h0);
    #10 reset_n = 1'b1;

    //           v  rd1        rd2        imm    rs1 rs2 rd alu    src rdm wem resm         rdw wew resw
    //           a_fwd        b_fwd      wd_fwd     a_raw  b_raw  wd_raw exp_alu
    vecs[0] = mk(1, 32'h11, 32'h22, 32'h10, 5, 6, 3, 3'b000, 0, 5, 1, 32'h1234, 5, 1, 32'hBEEF,
                 32'h1234, 32'h22, 32'h22, 32'h11, 32'h22, 32'h22, 3'b000);
    vecs[1] = mk(1, 32'h11, 32'h22, 32'h10, 5, 6, 3, 3'b001, 0, 7, 1, 32'h1234, 6, 1, 32'hBEEF,
                 32'h11, 32'hBEEF, 32'hBEEF, 32'h11, 32'h22, 32'h22, 3'b001);
    vecs[2] = mk(1, 32'h5, 32'h0, 32'h10, 1, 0, 3, 3'b010, 0, 0, 1, 32'hFFFF_FFFF, 0, 1, 32'hAAAA,
                 32'h5, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0, 3'b010);
    vecs[3] = mk(1, 32'h5, 32'h0, 32'h10, 1, 0, 3, 3'b011, 1, 0, 1, 32'hFFFF_FFFF, 0, 1, 32'hAAAA,
                 32'h5, 32'h10, 32'h0, 32'h5, 32'h10, 32'h0, 3'b011);
    vecs[4] = mk(1, 32'h44, 32'h66, 32'h10, 5, 6, 3, 3'b111, 0, 5, 0, 32'h1234, 5, 1, 32'hCAFE,
                 32'hCAFE, 32'h66, 32'h66, 32'h44, 32'h66, 32'h66, 3'b111);
    vecs[5] = mk(0, 32'h77, 32'h88, 32'h10, 9, 10, 3, 3'b101, 0, 0, 0, 32'h0, 0, 0, 32'h0,
                 32'h77, 32'h88, 32'h88, 32'h77, 32'h88, 32'h88, 3'b000);

    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      bus.valid_d = vecs[i].valid; bus.regwrite_d = 1'b1;
      bus.rd1_d = vecs[i].rd1; bus.rd2_d = vecs[i].rd2; bus.immext_d = vecs[i].imm;
      bus.rs1_d = vecs[i].rs1; bus.rs2_d = vecs[i].rs2; bus.rd_d = vecs[i].rd;
      bus.alucontrol_d = vecs[i].alu; bus.alusrc_d = vecs[i].alusrc;
      step();
      bus.rd_m = vecs[i].rdm; bus.regwrite_m = vecs[i].wem; bus.aluresult_m = vecs[i].resm;
      bus.rd_w = vecs[i].rdw; bus.regwrite_w = vecs[i].wew; bus.result_w = vecs[i].resw;
      #1;
      check($sformatf("vec%0d_srca", i), bus.srca_e, Fwd ? vecs[i].a_fwd : vecs[i].a_raw);
      check($sformatf("vec%0d_srcb", i), bus.srcb_e, Fwd ? vecs[i].b_fwd : vecs[i].b_raw);
      check($sformatf("vec%0d_wdata", i), bus.writedata_e,
            Fwd ? vecs[i].wd_fwd : vecs[i].wd_raw);
      check($sformatf("vec%0d_alucontrol", i), {29'b0, bus.alucontrol_e}, {29'b0, vecs[i].exp_alu});
      check($sformatf("vec%0d_valid", i), {31'b0, bus.valid_e}, {31'b0, vecs[i].valid});
      check($sformatf("vec%0d_regwrite", i), {31'b0, bus.regwrite_e}, {31'b0, vecs[i].valid});
    end

    // Load-use: lw x7 in EX, Decode reads x7 as rs2.
    clear_inputs();
    drive_instr(32'h0, 5'd2, 5'd0, 5'd7, 3'b000, 2'b01);
    step();
    bus.valid_d = 0; bus.rs1_d = 5'd1; bus.rs2_d = 5'd7;
    #1;
    check("lduse_rs2_hit", {31'b0, bus.lduse_stall}, 32'h1);
    bus.rs2_d = 5'd8;
    #1;
    check("lduse_no_hit", {31'b0, bus.lduse_stall}, 32'h0);
    bus.rs2_d = 5'd7; bus.flush_e = 1;
    step();
    check("lduse_flush_valid", {31'b0, bus.valid_e}, 32'h0);
    check("lduse_flush_rd", {27'b0, bus.rd_e}, 32'h0);
    check("lduse_after_flush", {31'b0, bus.lduse_stall}, 32'h0);

    // ALU producer in EX matching rs1_d: only a hazard without forwarding.
    clear_inputs();
    drive_instr(32'h0, 5'd2, 5'd3, 5'd4, 3'b000, 2'b00);
    step();
    bus.valid_d = 0; bus.rs1_d = 5'd4; bus.rs2_d = 5'd0;
    #1;
    check("alu_producer_stall", {31'b0, bus.lduse_stall}, Fwd ? 32'h0 : 32'h1);

    // Hold for three cycles, operands tracking newer M/W results, then hold+flush.
    clear_inputs();
    drive_instr(32'h55, 5'd3, 5'd0, 5'd9, 3'b100, 2'b00);
    step();
    bus.hold_e = 1;
    drive_instr(32'h99, 5'd11, 5'd0, 5'd12, 3'b110, 2'b00);
    for (int c = 0; c < 3; c++) begin
      bus.rd_m = (c == 0) ? 5'd3 : 5'd0; bus.regwrite_m = (c == 0);
      bus.aluresult_m = 32'h100;
      bus.rd_w = (c == 1) ? 5'd3 : 5'd0; bus.regwrite_w = (c == 1);
      bus.result_w = 32'h200;
      step();
      check($sformatf("hold%0d_alucontrol", c), {29'b0, bus.alucontrol_e}, 32'h4);
      check($sformatf("hold%0d_rd", c), {27'b0, bus.rd_e}, 32'h9);
      check($sformatf("hold%0d_valid", c), {31'b0, bus.valid_e}, 32'h1);
      check($sformatf("hold%0d_srca", c), bus.srca_e,
            !Fwd ? 32'h55 : (c == 0) ? 32'h100 : (c == 1) ? 32'h200 : 32'h55);
    end
    bus.flush_e = 1;
    step();
    check("holdflush_valid", {31'b0, bus.valid_e}, 32'h0);
    check("holdflush_alucontrol", {29'b0, bus.alucontrol_e}, 32'h0);
    check("holdflush_rd", {27'b0, bus.rd_e}, 32'h0);

    // Asynchronous reset mid-cycle.
    clear_inputs();
    drive_instr(32'h1, 5'd1, 5'd2, 5'd5, 3'b011, 2'b00);
    step();
    check("pre_reset_valid", {31'b0, bus.valid_e}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_valid", {31'b0, bus.valid_e}, 32'h0);
    check("async_reset_regwrite", {31'b0, bus.regwrite_e}, 32'h0);
    check("async_reset_alucontrol", {29'b0, bus.alucontrol_e}, 32'h0);
    reset_n = 1'b1;
    step();
    check("post_reset_capture", {31'b0, bus.valid_e}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
